// File: rtl/qspi_rom_arbiter.sv
// rtl/qspi_rom_arbiter.sv - two-port round-robin byte reader sharing one QPI flash ROM
// Optional one-entry last-byte cache enabled by defining QSPI_LAST_BYTE_CACHE_EN.
module qspi_rom_arbiter #(
  parameter int          ADDR_WIDTH    = 13,
  parameter logic [23:0] ROM_BASE      = 24'h000000,
  parameter logic [7:0]  CMD           = 8'hEB,
  parameter int          DUMMY_NIBBLES = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0_valid,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic                  req1_valid,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  output logic                  rsp0_valid,
  output logic                  rsp1_valid,
  output logic [7:0]            rsp_data,
  output logic                  busy,
  output logic                  spi_select,
  output logic                  spi_clk,
  output logic [3:0]            spi_dout,
  output logic                  spi_oe,
  input  logic [3:0]            spi_din
);

  typedef enum logic [2:0] {
    S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_DONE
  } state_t;

  state_t      state_q, state_d;
  logic        phase_q;
  logic [3:0]  cnt_q;
  logic        grant_q;
  logic        last_grant_q;
  logic [31:0] sh_q;
  logic [3:0]  data_hi_q;
  logic [7:0]  rsp_data_q;

  logic                  req_any;
  logic                  pick1;
  logic [ADDR_WIDTH-1:0] addr_sel;
  logic [23:0]           flash_addr;
  logic [3:0]            seg_last;
  logic                  nib_done;
  logic                  hit;

  assign req_any    = req0_valid | req1_valid;
  assign pick1      = req1_valid & (~req0_valid | ~last_grant_q);
  assign addr_sel   = pick1 ? req1_addr : req0_addr;
  assign flash_addr = ROM_BASE + {{(24-ADDR_WIDTH){1'b0}}, addr_sel};

`ifdef QSPI_LAST_BYTE_CACHE_EN
  logic        cache_valid_q;
  logic [23:0] cache_addr_q;
  logic [7:0]  cache_data_q;
  logic [23:0] faddr_q;

  assign hit = cache_valid_q && (cache_addr_q == flash_addr);
`else
  assign hit = 1'b0;
`endif

  // Index of the final nibble in each serial segment.
  always_comb begin
    seg_last = 4'd0;
    case (state_q)
      S_CMD:   seg_last = 4'd1;
      S_ADDR:  seg_last = 4'd5;
      S_DUMMY: seg_last = 4'(DUMMY_NIBBLES - 1);
      S_DATA:  seg_last = 4'd1;
      default: seg_last = 4'd0;
    endcase
  end

  assign nib_done = phase_q && (cnt_q == seg_last);

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_any) state_d = hit ? S_DONE : S_CMD;
      S_CMD:   if (nib_done) state_d = S_ADDR;
      S_ADDR:  if (nib_done) state_d = S_DUMMY;
      S_DUMMY: if (nib_done) state_d = S_DATA;
      S_DATA:  if (nib_done) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      phase_q      <= 1'b0;
      cnt_q        <= 4'd0;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      sh_q         <= 32'h0;
      data_hi_q    <= 4'h0;
      rsp_data_q   <= 8'h00;
`ifdef QSPI_LAST_BYTE_CACHE_EN
      cache_valid_q <= 1'b0;
      cache_addr_q  <= 24'h0;
      cache_data_q  <= 8'h00;
      faddr_q       <= 24'h0;
`endif
    end else begin
      if (state_q == S_IDLE || state_q == S_DONE) begin
        phase_q <= 1'b0;
        cnt_q   <= 4'd0;
      end else begin
        phase_q <= ~phase_q;
        if (phase_q) cnt_q <= nib_done ? 4'd0 : cnt_q + 4'd1;
      end

      if (state_q == S_IDLE && req_any) begin
        grant_q      <= pick1;
        last_grant_q <= pick1;
        sh_q         <= {CMD, flash_addr};
`ifdef QSPI_LAST_BYTE_CACHE_EN
        faddr_q <= flash_addr;
        if (hit) rsp_data_q <= cache_data_q;
`endif
      end

      if ((state_q == S_CMD || state_q == S_ADDR) && phase_q)
        sh_q <= {sh_q[27:0], 4'h0};

      // Flash nibbles are captured on the rising spi_clk cycle.
      if (state_q == S_DATA && phase_q) begin
        if (cnt_q == 4'd0) begin
          data_hi_q <= spi_din;
        end else begin
          rsp_data_q <= {data_hi_q, spi_din};
`ifdef QSPI_LAST_BYTE_CACHE_EN
          cache_valid_q <= 1'b1;
          cache_addr_q  <= faddr_q;
          cache_data_q  <= {data_hi_q, spi_din};
`endif
        end
      end
    end
  end

  always_comb begin
    busy       = (state_q != S_IDLE);
    spi_select = 1'b1;
    spi_clk    = 1'b0;
    spi_oe     = 1'b0;
    spi_dout   = 4'h0;
    rsp0_valid = 1'b0;
    rsp1_valid = 1'b0;
    rsp_data   = rsp_data_q;
    case (state_q)
      S_CMD, S_ADDR: begin
        spi_select = 1'b0;
        spi_clk    = phase_q;
        spi_oe     = 1'b1;
        spi_dout   = sh_q[31:28];
      end
      S_DUMMY, S_DATA: begin
        spi_select = 1'b0;
        spi_clk    = phase_q;
      end
      S_DONE: begin
        rsp0_valid = ~grant_q;
        rsp1_valid = grant_q;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_qspi_rom_arbiter.sv
// tb/tb_qspi_rom_arbiter.sv - directed self-checking bench for qspi_rom_arbiter
// Instance 0 uses defaults; instance 1 uses ROM_BASE=24'hFFFFF0, DUMMY_NIBBLES=6.
module tb_qspi_rom_arbiter;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic        r0v[2], r1v[2];
  logic [12:0] r0a[2], r1a[2];
  logic        p0v[2], p1v[2];
  logic [7:0]  rdata[2];
  logic        bsy[2], sel[2], sclk[2], oe[2];
  logic [3:0]  dout[2], din[2];
  logic [31:0] fsh[2];
  int          ncnt[2];

  int n_checks = 0;
  int n_pass   = 0;
  bit hit_full;

  function automatic logic [7:0] fmem(input logic [23:0] a);
    if (a == 24'h000FFC) return 8'hA5;
    return a[7:0] ^ a[15:8] ^ 8'h69;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    localparam int DMY = (g == 0) ? 4 : 6;
    logic [7:0] mb;

    qspi_rom_arbiter #(
      .ADDR_WIDTH(13),
      .ROM_BASE((g == 0) ? 24'h000000 : 24'hFFFFF0),
      .CMD(8'hEB),
      .DUMMY_NIBBLES(DMY)
    ) u_dut (
      .clk(clk), .reset(reset),
      .req0_valid(r0v[g]), .req0_addr(r0a[g]),
      .req1_valid(r1v[g]), .req1_addr(r1a[g]),
      .rsp0_valid(p0v[g]), .rsp1_valid(p1v[g]), .rsp_data(rdata[g]),
      .busy(bsy[g]), .spi_select(sel[g]), .spi_clk(sclk[g]),
      .spi_dout(dout[g]), .spi_oe(oe[g]), .spi_din(din[g])
    );

    // Flash model: shifts in command+address, then returns fmem(address).
    always @(posedge clk) begin
      if (sel[g] !== 1'b0) begin
        ncnt[g] <= 0;
      end else if (sclk[g]) begin
        if (ncnt[g] < 8) fsh[g] <= {fsh[g][27:0], dout[g]};
        ncnt[g] <= ncnt[g] + 1;
      end
    end

    assign mb     = fmem(fsh[g][23:0]);
    assign din[g] = (ncnt[g] == 8 + DMY) ? mb[7:4] :
                    (ncnt[g] == 9 + DMY) ? mb[3:0] : 4'h0;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic do_req(input int k, input int port, input logic [12:0] addr,
                        input logic [7:0] exp_data, input bit full);
    int dmy = (k == 0) ? 4 : 6;
    int lat = 0, sel_lo = 0, oe_n = 0, bad_dout = 0, dual = 0;
    bit got = 0;
    logic [23:0] fa;
    fa = ((k == 0) ? 24'h000000 : 24'hFFFFF0) + {11'b0, addr};
    if (port == 0) begin r0v[k] = 1'b1; r0a[k] = addr; end
    else           begin r1v[k] = 1'b1; r1a[k] = addr; end
    while (!got && lat < 200) begin
      @(negedge clk);
      lat++;
      if (lat == 2) begin
        if (port == 0) r0a[k] = ~addr;
        else           r1a[k] = ~addr;
      end
      if (!sel[k]) sel_lo++;
      if (oe[k]) oe_n++;
      if (!oe[k] && dout[k] != 4'h0) bad_dout++;
      if (p0v[k] && p1v[k]) dual++;
      if ((port == 0) ? p0v[k] : p1v[k]) begin
        got = 1;
        check("rsp_data", rdata[k], exp_data);
        check("sel_done", sel[k], 1'b1);
        check("sclk_done", sclk[k], 1'b0);
      end
    end
    r0v[k] = 1'b0;
    r1v[k] = 1'b0;
    check("latency", lat, full ? 2 * (10 + dmy) + 1 : 1);
    check("sel_low_cycles", sel_lo, full ? 2 * (10 + dmy) : 0);
    check("oe_cycles", oe_n, full ? 16 : 0);
    check("dout_when_not_oe", bad_dout, 0);
    check("dual_rsp", dual, 0);
    if (full) check("cmd_addr_on_pins", fsh[k], {8'hEB, fa});
    @(negedge clk);
    check("busy_after", bsy[k], 1'b0);
  endtask

  initial begin
    int seen;
    int port_seen;
    int wait_n;
    int pulses;
`ifdef QSPI_LAST_BYTE_CACHE_EN
    hit_full = 1'b0;
`else
    hit_full = 1'b1;
`endif
    for (int k = 0; k < 2; k++) begin
      r0v[k] = 1'b0; r1v[k] = 1'b0; r0a[k] = 13'h0; r1a[k] = 13'h0;
    end
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;

    for (int k = 0; k < 2; k++) begin
      check("rst_sel", sel[k], 1'b1);
      check("rst_sclk", sclk[k], 1'b0);
      check("rst_oe", oe[k], 1'b0);
      check("rst_dout", dout[k], 4'h0);
      check("rst_busy", bsy[k], 1'b0);
      check("rst_rsp", {p0v[k], p1v[k]}, 2'b00);
      check("rst_data", rdata[k], 8'h00);
    end

    do_req(0, 0, 13'h0FFC, 8'hA5, 1'b1);
    do_req(0, 1, 13'h1234, 8'h4F, 1'b1);
    do_req(0, 1, 13'h1234, 8'h4F, hit_full);
    do_req(0, 0, 13'h0FFC, 8'hA5, 1'b1);
    do_req(1, 0, 13'h0020, 8'h79, 1'b1);

    r0v[0] = 1'b1; r0a[0] = 13'h0FFC;
    repeat (10) @(negedge clk);
    reset = 1'b1;
    r0v[0] = 1'b0;
    @(negedge clk);
    check("midrst_sel", sel[0], 1'b1);
    check("midrst_oe", oe[0], 1'b0);
    check("midrst_sclk", sclk[0], 1'b0);
    check("midrst_busy", bsy[0], 1'b0);
    check("midrst_rsp", p0v[0], 1'b0);
    check("midrst_data", rdata[0], 8'h00);
    reset = 1'b0;
    pulses = 0;
    repeat (40) begin
      @(negedge clk);
      if (p0v[0] || p1v[0]) pulses++;
    end
    check("midrst_no_pulse", pulses, 0);
    do_req(0, 0, 13'h1ABC, 8'hCF, 1'b1);

    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    r0v[0] = 1'b1; r0a[0] = 13'h0FFC;
    r1v[0] = 1'b1; r1a[0] = 13'h1234;
    for (int i = 0; i < 4; i++) begin
      seen = 0;
      port_seen = -1;
      wait_n = 0;
      while (!seen && wait_n < 100) begin
        @(negedge clk);
        wait_n++;
        if (p0v[0] && p1v[0]) check("rr_dual", 1, 0);
        if (p0v[0] || p1v[0]) begin
          seen = 1;
          port_seen = p1v[0] ? 1 : 0;
        end
      end
      if (i == 3) begin r0v[0] = 1'b0; r1v[0] = 1'b0; end
      check("rr_port", port_seen, i % 2);
      check("rr_data", rdata[0], (i % 2) ? 8'h4F : 8'hA5);
    end
    repeat (2) @(negedge clk);
    check("rr_idle", bsy[0], 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
